fetch_unit: RTL

- PC-generation and fetch-buffer stage directly upstream of icache.
- Drives the pc_icache_if request side (pc_valid/pc_addr), takes instr_valid/instr back, and queues {pc, instr} pairs in a small FIFO for decode over a valid/ready handshake.
- Handles branch/jump redirects from execute, including redirects that arrive while an icache request is in flight.

---
 rtl/fetch_unit_if.sv | 19 +
 rtl/fetch_unit.sv | 77 +++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: icache request/response and decode handshake bundle for the fetch stage
interface fetch_unit_if;
   logic        pc_valid;
   logic [31:0] pc_addr;
   logic        instr_valid;
   logic [31:0] instr;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   modport master (
      output pc_valid, pc_addr, fetch_valid, fetch_pc, fetch_instr,
      input  instr_valid, instr, fetch_ready
   );
   modport slave (
      input  pc_valid, pc_addr, fetch_valid, fetch_pc, fetch_instr,
      output instr_valid, instr, fetch_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, single-outstanding icache requests and a small {pc, instr} buffer for decode
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, FETCH, GAP} state_t;
   state_t        state;
   logic [31:0]   mem_pc    [FIFO_DEPTH];
   logic [31:0]   mem_instr [FIFO_DEPTH];
   logic [AW-1:0] rd, wr, rd_n;
   logic [AW:0]   count, count_n;
   logic          squash;
   logic [31:0]   pend;
   logic [31:0]   target;
   logic          push, pop, room, head_new;
   always_comb begin
      target   = redirect_valid ? (redirect_pc & ~32'd3) : bus.pc_addr;
      pop      = bus.fetch_valid && bus.fetch_ready && !redirect_valid;
      push     = (state == FETCH) && bus.instr_valid && !squash && !redirect_valid;
      rd_n     = rd + AW'(pop);
      count_n  = redirect_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      room     = count_n < (AW+1)'(FIFO_DEPTH);
      // a push into an otherwise empty buffer becomes the head directly
      head_new = push && (count_n == (AW+1)'(1));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.pc_valid    <= 1'b0;
         bus.pc_addr     <= RESET_PC & ~32'd3;
         squash          <= 1'b0;
         pend            <= '0;
         rd              <= '0;
         wr              <= '0;
         count           <= '0;
         bus.fetch_valid <= 1'b0;
         bus.fetch_pc    <= '0;
         bus.fetch_instr <= 32'h0000_0013;
      end else begin
         if (push) begin
            mem_pc[wr]    <= bus.pc_addr;
            mem_instr[wr] <= bus.instr;
         end
         rd              <= redirect_valid ? '0 : rd_n;
         wr              <= redirect_valid ? '0 : wr + AW'(push);
         count           <= count_n;
         bus.fetch_valid <= count_n != '0;
         if (count_n != '0) begin
            bus.fetch_pc    <= head_new ? bus.pc_addr : mem_pc[rd_n];
            bus.fetch_instr <= head_new ? bus.instr : mem_instr[rd_n];
         end
         if (state == FETCH) begin
            if (bus.instr_valid) begin
               bus.pc_valid <= 1'b0;
               bus.pc_addr  <= redirect_valid ? target : squash ? pend : bus.pc_addr + 32'd4;
               squash       <= 1'b0;
               state        <= GAP;
            end else if (redirect_valid) begin
               // request stays on the bus; its response will be dropped
               squash <= 1'b1;
               pend   <= target;
            end
         end else begin
            bus.pc_addr  <= target;
            bus.pc_valid <= room;
            state        <= room ? FETCH : IDLE;
         end
      end
   end
endmodule
